pool_1: RTL and testbench
=========================

POOL_1 -- requirements
Module: pool_1

Interface
REQ-001 Parameter RD_LAT, default 2, read latency of fm_bram_1 in cycles (enable/address to valid dout); legal 1..4.
REQ-002 Parameter NUM_CH, default 6, number of conv_1 output channels held in fm_bram_1.
REQ-003 clk  input  1  single clock for all logic; everything on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pool_1_en  input  1  level enable; a rising edge starts one full pass.
REQ-006 fm_bram_1_ena  output  1  port A read enable.
REQ-007 fm_bram_1_enb  output  1  port B read enable.
REQ-008 fm_bram_1_addra  output  7  port A read address.
REQ-009 fm_bram_1_addrb  output  7  port B read address.
REQ-010 fm_bram_1_douta  input  896  port A read data, 56 lanes x 16-bit signed, lane i at bits [16i +: 16].
REQ-011 fm_bram_1_doutb  input  896  port B read data, same lane format.
REQ-012 fm_bram_2_wea  output  1  pooled-result write enable.
REQ-013 fm_bram_2_addra  output  6  pooled-result write address.
REQ-014 fm_bram_2_dina  output  448  pooled-result data, 28 lanes x 16-bit signed.
REQ-015 pool_1_finish  output  1  pass-complete flag, level.

Function
REQ-016 Input layout is fixed: word c*14+k (c < NUM_CH, k < 14) holds row 2k of channel c in lanes 0..27 and row 2k+1 in lanes 28..55.
REQ-017 Output layout is fixed: word p = c*7+m holds pooled row 2m of channel c in lanes 0..13 and pooled row 2m+1 in lanes 14..27.
REQ-018 FSM states: IDLE, READ, DRAIN, DONE.
REQ-019 IDLE->READ on pool_1_en=1 while the pool_1_en value registered one cycle earlier is 0 (start cycle T0).
REQ-020 READ: one read per cycle from T1; pair index p = 0..NUM_CH*7-1; addra = 2p, addrb = 2p+1; ena = enb = 1.
REQ-021 READ->DRAIN after p = NUM_CH*7-1 has been issued; DRAIN issues no reads (ena = enb = 0).
REQ-022 A valid shift register of length RD_LAT, plus one compute register stage, tracks each issued read.
REQ-023 Pooling: out lane j (j < 14) from douta = signed max(lane 2j, lane 2j+1, lane 28+2j, lane 28+2j+1); out lane 14+j is the same function applied to doutb.
REQ-024 Max uses 16-bit two's-complement comparison; ties return the common value; no saturation, no ReLU, no width growth.
REQ-025 The result of the read issued in cycle t is written in cycle t+RD_LAT+1 with wea=1, addra=p, and dina registered.
REQ-026 wea is 1 for exactly NUM_CH*7 cycles, back to back, with addresses 0..41 in order for default parameters.
REQ-027 DRAIN->DONE in the cycle after the last write; pool_1_finish is 1 throughout DONE.
REQ-028 DONE->IDLE when pool_1_en=0; pool_1_finish clears in the same transition.
REQ-029 Abort: pool_1_en=0 in READ or DRAIN -> IDLE on the next cycle; in-flight valid bits cleared; no further wea pulses; finish is not asserted.
REQ-030 Restart after abort or DONE requires a fresh rising edge; the pass then restarts from p = 0.
REQ-031 pool_1_en held high in IDLE without a rising edge produces no activity.
REQ-032 Address counters and write addresses do not wrap: p stops at NUM_CH*7-1.

Reset
REQ-033 rst=1 -> next cycle: state IDLE, all valid bits 0, ena=enb=wea=0, addra=addrb=0, fm_bram_2_addra=0, dina=0, pool_1_finish=0, registered pool_1_en=0.
REQ-034 rst takes priority over pool_1_en, mid-pass included; the first wea pulse after the new pass starts has addra=0.
REQ-035 pool_1_en held high across reset release counts as a rising edge at the first non-reset cycle.

Verification
REQ-036 Ramp: every input lane holds its own lane index, RD_LAT=2, rising edge at T0 -> reads T1..T42; wea T4..T45; word 0 lane j = 29+2j for both halves; finish=1 at T46.
REQ-037 Signed: lanes {0,1,28,29} = {-5,-3,-32768,-1} -> out lane 0 = -1 (0xFFFF); all four = 0x8000 -> 0x8000.
REQ-038 Ordering: douta word n = n in all lanes, doutb word n = n in all lanes -> write p has lanes 0..13 = 2p and lanes 14..27 = 2p+1.
REQ-039 Abort: pool_1_en dropped at T10 -> no reads after T10, no wea after T11, finish=0; new rising edge -> first write addr 0.
REQ-040 Reset mid-DRAIN -> all outputs 0 next cycle; pool_1_en held high -> full 42-write pass from addr 0.
REQ-041 RD_LAT=4 sweep -> first wea at T6, last at T47, 42 writes total, finish at T48.

Source files
------------

// File: rtl/pool_1_if.sv
// pool_1_if: groups the pooling engine's enable, fm_bram_1 read ports,
// fm_bram_2 write port and finish flag.
//   master : pool_1 side (drives read/write ports, receives enable and read data)
//   slave  : environment side (drives enable and read data, observes the rest)
interface pool_1_if;
    logic         pool_1_en;
    logic         fm_bram_1_ena;
    logic         fm_bram_1_enb;
    logic [6:0]   fm_bram_1_addra;
    logic [6:0]   fm_bram_1_addrb;
    logic [895:0] fm_bram_1_douta;
    logic [895:0] fm_bram_1_doutb;
    logic         fm_bram_2_wea;
    logic [5:0]   fm_bram_2_addra;
    logic [447:0] fm_bram_2_dina;
    logic         pool_1_finish;

    modport master (
        input  pool_1_en,
        output fm_bram_1_ena,
        output fm_bram_1_enb,
        output fm_bram_1_addra,
        output fm_bram_1_addrb,
        input  fm_bram_1_douta,
        input  fm_bram_1_doutb,
        output fm_bram_2_wea,
        output fm_bram_2_addra,
        output fm_bram_2_dina,
        output pool_1_finish
    );

    modport slave (
        output pool_1_en,
        input  fm_bram_1_ena,
        input  fm_bram_1_enb,
        input  fm_bram_1_addra,
        input  fm_bram_1_addrb,
        output fm_bram_1_douta,
        output fm_bram_1_doutb,
        input  fm_bram_2_wea,
        input  fm_bram_2_addra,
        input  fm_bram_2_dina,
        input  pool_1_finish
    );
endinterface

// File: rtl/pool_1.sv
// pool_1: 2x2 max-pooling pass over the conv_1 feature maps.
// Each input word pair (2p, 2p+1) holds four image rows of one channel; the
// pair is read through both BRAM ports in one cycle and reduced to one output
// word p (two pooled rows of 14 lanes each).
// Ports:
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset
//   bus      : pool_1_if.master -- pool_1_en, fm_bram_1 read ports A/B,
//              fm_bram_2 write port, pool_1_finish
// Parameters:
//   RD_LAT   : fm_bram_1 read latency in cycles (1..4)
//   NUM_CH   : number of channels in fm_bram_1
module pool_1 #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned NUM_CH = 6
) (
    input  logic     clk,
    input  logic     rst,
    pool_1_if.master bus
);

    localparam int unsigned LANE_W    = 16;
    localparam int unsigned IN_HALF   = 28;
    localparam int unsigned OUT_HALF  = 14;
    localparam int unsigned OUT_W     = 2 * OUT_HALF * LANE_W;
    localparam int unsigned NUM_WORDS = NUM_CH * 7;
    localparam logic [5:0]  LAST_P    = 6'(NUM_WORDS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              en_q, en_d;
    logic [5:0]        rd_p_q, rd_p_d;
    logic              ena_q, ena_d;
    logic [6:0]        addra_q, addra_d;
    logic [6:0]        addrb_q, addrb_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [5:0]        wr_cnt_q, wr_cnt_d;
    logic              wea_q, wea_d;
    logic [5:0]        addr2_q, addr2_d;
    logic [OUT_W-1:0]  dina_q, dina_d;
    logic              fin_q, fin_d;
    logic [OUT_W-1:0]  pooled_c;
    logic              abort_c;

    // Signed 16-bit maximum; on a tie either operand is the same value.
    function automatic logic [LANE_W-1:0] max2(input logic [LANE_W-1:0] a,
                                               input logic [LANE_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [LANE_W-1:0] max4(input logic [LANE_W-1:0] a,
                                               input logic [LANE_W-1:0] b,
                                               input logic [LANE_W-1:0] c,
                                               input logic [LANE_W-1:0] d);
        return max2(max2(a, b), max2(c, d));
    endfunction

    // 2x2 window: two adjacent lanes from each of the two rows in a word.
    always_comb begin
        pooled_c = '0;
        for (int j = 0; j < int'(OUT_HALF); j++) begin
            pooled_c[LANE_W*j +: LANE_W] = max4(
                bus.fm_bram_1_douta[LANE_W*(2*j)             +: LANE_W],
                bus.fm_bram_1_douta[LANE_W*(2*j+1)           +: LANE_W],
                bus.fm_bram_1_douta[LANE_W*(IN_HALF+2*j)     +: LANE_W],
                bus.fm_bram_1_douta[LANE_W*(IN_HALF+2*j+1)   +: LANE_W]);
            pooled_c[LANE_W*(OUT_HALF+j) +: LANE_W] = max4(
                bus.fm_bram_1_doutb[LANE_W*(2*j)             +: LANE_W],
                bus.fm_bram_1_doutb[LANE_W*(2*j+1)           +: LANE_W],
                bus.fm_bram_1_doutb[LANE_W*(IN_HALF+2*j)     +: LANE_W],
                bus.fm_bram_1_doutb[LANE_W*(IN_HALF+2*j+1)   +: LANE_W]);
        end
    end

    // Next-state, read issue and write-back logic.
    always_comb begin
        state_d  = state_q;
        en_d     = bus.pool_1_en;
        rd_p_d   = rd_p_q;
        ena_d    = 1'b0;
        addra_d  = addra_q;
        addrb_d  = addrb_q;
        // Valid bits follow each issued read until its data arrives.
        vld_d    = RD_LAT'({vld_q, ena_q});
        wr_cnt_d = wr_cnt_q;
        wea_d    = 1'b0;
        addr2_d  = addr2_q;
        dina_d   = dina_q;
        fin_d    = fin_q;
        abort_c  = ((state_q == READ) || (state_q == DRAIN)) && !bus.pool_1_en;

        // Data arriving for an issued read is pooled and written next cycle.
        if (vld_q[RD_LAT-1]) begin
            wea_d    = 1'b1;
            addr2_d  = wr_cnt_q;
            dina_d   = pooled_c;
            wr_cnt_d = (wr_cnt_q == LAST_P) ? wr_cnt_q : wr_cnt_q + 6'd1;
        end

        case (state_q)
            IDLE: begin
                fin_d = 1'b0;
                if (bus.pool_1_en && !en_q) begin
                    state_d  = READ;
                    ena_d    = 1'b1;
                    rd_p_d   = 6'd0;
                    addra_d  = 7'd0;
                    addrb_d  = 7'd1;
                    wr_cnt_d = 6'd0;
                end
            end
            READ: begin
                if (rd_p_q == LAST_P) begin
                    state_d = DRAIN;
                end else begin
                    ena_d   = 1'b1;
                    rd_p_d  = rd_p_q + 6'd1;
                    addra_d = {rd_p_d, 1'b0};
                    addrb_d = {rd_p_d, 1'b1};
                end
            end
            DRAIN: begin
                // Last write is on the bus this cycle.
                if (wea_q && (addr2_q == LAST_P)) begin
                    state_d = DONE;
                    fin_d   = 1'b1;
                end
            end
            DONE: begin
                fin_d = 1'b1;
                if (!bus.pool_1_en) begin
                    state_d = IDLE;
                    fin_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Enable dropped mid-pass: discard everything still in flight.
        if (abort_c) begin
            state_d  = IDLE;
            ena_d    = 1'b0;
            rd_p_d   = rd_p_q;
            vld_d    = '0;
            wea_d    = 1'b0;
            addr2_d  = addr2_q;
            dina_d   = dina_q;
            wr_cnt_d = wr_cnt_q;
            fin_d    = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            rd_p_q   <= '0;
            ena_q    <= 1'b0;
            addra_q  <= '0;
            addrb_q  <= '0;
            vld_q    <= '0;
            wr_cnt_q <= '0;
            wea_q    <= 1'b0;
            addr2_q  <= '0;
            dina_q   <= '0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            rd_p_q   <= rd_p_d;
            ena_q    <= ena_d;
            addra_q  <= addra_d;
            addrb_q  <= addrb_d;
            vld_q    <= vld_d;
            wr_cnt_q <= wr_cnt_d;
            wea_q    <= wea_d;
            addr2_q  <= addr2_d;
            dina_q   <= dina_d;
            fin_q    <= fin_d;
        end
    end

    assign bus.fm_bram_1_ena   = ena_q;
    assign bus.fm_bram_1_enb   = ena_q;
    assign bus.fm_bram_1_addra = addra_q;
    assign bus.fm_bram_1_addrb = addrb_q;
    assign bus.fm_bram_2_wea   = wea_q;
    assign bus.fm_bram_2_addra = addr2_q;
    assign bus.fm_bram_2_dina  = dina_q;
    assign bus.pool_1_finish   = fin_q;

endmodule

// File: tb/tb_pool_1.sv
// tb_pool_1: drives two pool_1 instances (RD_LAT 2 and 4) from one shared
// feature-map memory and checks every read, write and finish flag against a
// reference computed directly from the pooling rules.
module tb_pool_1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    pool_1_if b2();
    pool_1_if b4();

    pool_1 #(.RD_LAT(2), .NUM_CH(6)) dut2 (.clk(clk), .rst(rst), .bus(b2.master));
    pool_1 #(.RD_LAT(4), .NUM_CH(6)) dut4 (.clk(clk), .rst(rst), .bus(b4.master));

    assign b2.pool_1_en = en;
    assign b4.pool_1_en = en;

    // Feature-map memory and BRAM read pipelines.
    logic [895:0] mem [0:83];
    logic [895:0] pa2 [0:1];
    logic [895:0] pb2 [0:1];
    logic [895:0] pa4 [0:3];
    logic [895:0] pb4 [0:3];

    function automatic logic [895:0] rd(input logic [6:0] a);
        return (int'(a) < 84) ? mem[a] : '0;
    endfunction

    always @(posedge clk) begin
        pa2[0] <= rd(b2.fm_bram_1_addra);
        pb2[0] <= rd(b2.fm_bram_1_addrb);
        pa2[1] <= pa2[0];
        pb2[1] <= pb2[0];
        pa4[0] <= rd(b4.fm_bram_1_addra);
        pb4[0] <= rd(b4.fm_bram_1_addrb);
        for (int i = 1; i < 4; i++) begin
            pa4[i] <= pa4[i-1];
            pb4[i] <= pb4[i-1];
        end
    end
    assign b2.fm_bram_1_douta = pa2[1];
    assign b2.fm_bram_1_doutb = pb2[1];
    assign b4.fm_bram_1_douta = pa4[3];
    assign b4.fm_bram_1_doutb = pb4[3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [447:0] act, input logic [447:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Event logs captured at the falling edge.
    typedef struct {
        int           c;
        int           addr;
        logic [447:0] data;
    } wr_t;
    typedef struct {
        int c;
        int a;
        int b;
        int ea;
        int eb;
    } rd_t;

    wr_t wq2[$];
    wr_t wq4[$];
    rd_t rq2[$];
    rd_t rq4[$];
    int  fin2 = -1;
    int  fin4 = -1;

    always @(negedge clk) begin
        if (b2.fm_bram_2_wea)
            wq2.push_back('{cyc, int'(b2.fm_bram_2_addra), b2.fm_bram_2_dina});
        if (b4.fm_bram_2_wea)
            wq4.push_back('{cyc, int'(b4.fm_bram_2_addra), b4.fm_bram_2_dina});
        if (b2.fm_bram_1_ena || b2.fm_bram_1_enb)
            rq2.push_back('{cyc, int'(b2.fm_bram_1_addra), int'(b2.fm_bram_1_addrb),
                            int'(b2.fm_bram_1_ena), int'(b2.fm_bram_1_enb)});
        if (b4.fm_bram_1_ena || b4.fm_bram_1_enb)
            rq4.push_back('{cyc, int'(b4.fm_bram_1_addra), int'(b4.fm_bram_1_addrb),
                            int'(b4.fm_bram_1_ena), int'(b4.fm_bram_1_enb)});
        if (b2.pool_1_finish && fin2 < 0) fin2 = cyc;
        if (b4.pool_1_finish && fin4 < 0) fin4 = cyc;
    end

    task automatic clear_logs();
        wq2.delete(); wq4.delete(); rq2.delete(); rq4.delete();
        fin2 = -1; fin4 = -1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference pooling: each output lane is the signed max of its 2x2 window.
    function automatic logic [447:0] pool_ref(input logic [895:0] a, input logic [895:0] b);
        logic [447:0]       r;
        logic [895:0]       w;
        logic signed [15:0] s;
        int                 m, idx;
        r = '0;
        for (int h = 0; h < 2; h++) begin
            w = (h == 0) ? a : b;
            for (int j = 0; j < 14; j++) begin
                m = -100000;
                for (int k = 0; k < 4; k++) begin
                    idx = (k < 2) ? (2*j + k) : (28 + 2*j + k - 2);
                    s = w[16*idx +: 16];
                    if (int'(s) > m) m = int'(s);
                end
                r[16*(14*h + j) +: 16] = 16'(m);
            end
        end
        return r;
    endfunction

    task automatic check_pass(input int lat, input int t0);
        wr_t w[$];
        rd_t r[$];
        int  f;
        if (lat == 2) begin w = wq2; r = rq2; f = fin2; end
        else          begin w = wq4; r = rq4; f = fin4; end
        chk($sformatf("L%0d write count", lat), w.size(), 42);
        for (int i = 0; i < w.size() && i < 42; i++) begin
            chk($sformatf("L%0d write %0d cycle", lat, i), w[i].c, t0 + lat + 2 + i);
            chk($sformatf("L%0d write %0d addr", lat, i), w[i].addr, i);
            chk($sformatf("L%0d write %0d data", lat, i), w[i].data,
                pool_ref(mem[2*i], mem[2*i+1]));
        end
        chk($sformatf("L%0d read count", lat), r.size(), 42);
        for (int i = 0; i < r.size() && i < 42; i++) begin
            chk($sformatf("L%0d read %0d cycle", lat, i), r[i].c, t0 + 1 + i);
            chk($sformatf("L%0d read %0d addra", lat, i), r[i].a, 2*i);
            chk($sformatf("L%0d read %0d addrb", lat, i), r[i].b, 2*i + 1);
            chk($sformatf("L%0d read %0d enables", lat, i), r[i].ea + r[i].eb, 2);
        end
        chk($sformatf("L%0d finish cycle", lat), f, t0 + lat + 44);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " L2 ctrl"}, {b2.fm_bram_1_ena, b2.fm_bram_1_enb, b2.fm_bram_2_wea,
            b2.fm_bram_1_addra, b2.fm_bram_1_addrb, b2.fm_bram_2_addra, b2.pool_1_finish}, '0);
        chk({nm, " L2 dina"}, b2.fm_bram_2_dina, '0);
        chk({nm, " L4 ctrl"}, {b4.fm_bram_1_ena, b4.fm_bram_1_enb, b4.fm_bram_2_wea,
            b4.fm_bram_1_addra, b4.fm_bram_1_addrb, b4.fm_bram_2_addra, b4.pool_1_finish}, '0);
        chk({nm, " L4 dina"}, b4.fm_bram_2_dina, '0);
    endtask

    task automatic fill_random();
        for (int wi = 0; wi < 84; wi++)
            for (int l = 0; l < 28; l++)
                mem[wi][32*l +: 32] = $urandom;
    endtask

    // Start a pass with a rising edge, let both latencies finish, then check.
    task automatic full_pass();
        int t0;
        clear_logs();
        en = 1'b1;
        t0 = cyc;
        tick(56);
        check_pass(2, t0);
        check_pass(4, t0);
    endtask

    task automatic release_en();
        en = 1'b0;
        tick(2);
    endtask

    typedef struct packed {
        logic [15:0] l0;
        logic [15:0] l1;
        logic [15:0] l2;
        logic [15:0] l3;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t tv [0:7];
        int   t0, mx;

        tv[0] = '{16'hFFFB, 16'hFFFD, 16'h8000, 16'hFFFF, 16'hFFFF};
        tv[1] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        tv[2] = '{16'd1,    16'd2,    16'd3,    16'd4,    16'd4};
        tv[3] = '{16'd7,    16'd7,    16'd7,    16'd7,    16'd7};
        tv[4] = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFF};
        tv[5] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'h7FFF};
        tv[6] = '{16'hFF9C, 16'd5,    16'hFFF9, 16'h0000, 16'd5};
        tv[7] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};

        // Reset state.
        rst = 1'b1;
        en  = 1'b0;
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(1);

        // Ramp: each lane holds its own index.
        for (int wi = 0; wi < 84; wi++)
            for (int l = 0; l < 56; l++)
                mem[wi][16*l +: 16] = 16'(l);
        full_pass();
        if (wq2.size() > 0) begin
            chk("ramp lane0", wq2[0].data[15:0], 29);
            chk("ramp lane13", wq2[0].data[16*13 +: 16], 55);
            chk("ramp lane14", wq2[0].data[16*14 +: 16], 29);
        end else begin
            chk("ramp first write present", wq2.size(), 1);
        end

        // Enable held high in DONE: no activity, finish stays set.
        clear_logs();
        tick(10);
        chk("done idle activity", wq2.size() + rq2.size() + wq4.size() + rq4.size(), 0);
        chk("done finish L2", b2.pool_1_finish, 1);
        chk("done finish L4", b4.pool_1_finish, 1);
        en = 1'b0;
        tick(1);
        chk("finish clear L2", b2.pool_1_finish, 0);
        chk("finish clear L4", b4.pool_1_finish, 0);
        tick(1);

        // Table vectors in window j of word pair 0, random elsewhere.
        fill_random();
        for (int j = 0; j < 8; j++)
            for (int h = 0; h < 2; h++) begin
                mem[h][16*(2*j)      +: 16] = tv[j].l0;
                mem[h][16*(2*j+1)    +: 16] = tv[j].l1;
                mem[h][16*(28+2*j)   +: 16] = tv[j].l2;
                mem[h][16*(28+2*j+1) +: 16] = tv[j].l3;
            end
        full_pass();
        for (int j = 0; j < 8; j++) begin
            if (wq2.size() > 0 && wq4.size() > 0) begin
                chk($sformatf("vec %0d L2 A", j), wq2[0].data[16*j +: 16], tv[j].exp);
                chk($sformatf("vec %0d L2 B", j), wq2[0].data[16*(14+j) +: 16], tv[j].exp);
                chk($sformatf("vec %0d L4 A", j), wq4[0].data[16*j +: 16], tv[j].exp);
            end else begin
                chk($sformatf("vec %0d write present", j), 0, 1);
            end
        end
        release_en();

        // Ordering: word n holds n everywhere.
        for (int wi = 0; wi < 84; wi++)
            for (int l = 0; l < 56; l++)
                mem[wi][16*l +: 16] = 16'(wi);
        full_pass();
        if (wq2.size() > 5) begin
            chk("order w5 lane0", wq2[5].data[15:0], 10);
            chk("order w5 lane14", wq2[5].data[16*14 +: 16], 11);
        end
        release_en();

        // Random passes.
        repeat (2) begin
            fill_random();
            full_pass();
            release_en();
        end

        // Abort at T10, then restart.
        fill_random();
        clear_logs();
        en = 1'b1;
        t0 = cyc;
        tick(10);
        en = 1'b0;
        tick(20);
        mx = -1;
        foreach (rq2[i]) if (rq2[i].c > mx) mx = rq2[i].c;
        chk("abort L2 last read", mx, t0 + 10);
        chk("abort L2 read count", rq2.size(), 10);
        mx = -1;
        foreach (rq4[i]) if (rq4[i].c > mx) mx = rq4[i].c;
        chk("abort L4 last read", mx, t0 + 10);
        mx = -1;
        foreach (wq2[i]) if (wq2[i].c > mx) mx = wq2[i].c;
        chk("abort L2 no late wea", (mx <= t0 + 11), 1);
        mx = -1;
        foreach (wq4[i]) if (wq4[i].c > mx) mx = wq4[i].c;
        chk("abort L4 no late wea", (mx <= t0 + 11), 1);
        chk("abort L2 finish", fin2, -1);
        chk("abort L4 finish", fin4, -1);
        full_pass();
        release_en();

        // Reset during DRAIN with enable held high, then a full pass.
        fill_random();
        clear_logs();
        en = 1'b1;
        tick(44);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_zero("mid-drain reset");
        clear_logs();
        t0 = cyc;
        tick(56);
        check_pass(2, t0);
        check_pass(4, t0);
        release_en();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
